down_timer: RTL and testbench



---
 rtl/down_timer_pkg.sv | 14 +
 rtl/down_timer_dec_core.sv | 34 +++
 rtl/down_timer.sv | 119 +++++++++++
 tb/tb_down_timer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/down_timer_pkg.sv
// Shared types and constants for the down_timer block.
package down_timer_pkg;

  // Default counter width in bits.
  localparam int unsigned DEFAULT_WIDTH = 3;

  // Control FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/down_timer_dec_core.sv
// dec_core: n-bit down-counting register with clr > ld > dec priority
// and an "equals one" compare used for terminal-count detection.
module dec_core #(
  parameter int unsigned n = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_ld,
  input  logic         i_dec,
  input  logic [n-1:0] i_din,
  output logic [n-1:0] o_q,
  output logic         o_is_one
);

  logic [n-1:0] r_q;

  // Count register: clear, load, or decrement by one.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_ld) begin
      r_q <= i_din;
    end else if (i_dec) begin
      r_q <= r_q - n'(1);
    end
  end

  assign o_q      = r_q;
  assign o_is_one = (r_q == n'(1));

endmodule

// File: rtl/down_timer.sv
// down_timer: loadable down-counting timer with borrow-out, busy level
// and one-cycle done pulse. Optional auto-reload via
// DOWN_TIMER_AUTO_RELOAD_EN (DONE re-enters RUN with the last loaded value).
module down_timer
  import down_timer_pkg::*;
#(
  parameter int unsigned n = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic [n-1:0] din,
  input  logic         en,
  output logic [n-1:0] pout,
  output logic         busy,
  output logic         done,
  output logic         bo
);

  state_t       r_state;
  state_t       w_state_nxt;
  logic         r_busy;
  logic         r_done;
  logic         w_busy_nxt;
  logic         w_done_nxt;
  logic         w_core_ld;
  logic [n-1:0] w_core_din;
  logic         w_core_dec;
  logic [n-1:0] w_pout;
  logic         w_is_one;

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
  logic [n-1:0] r_reload;

  // Reload register captures every load; clr leaves it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reload <= '0;
    end else if (!clr && ld) begin
      r_reload <= din;
    end
  end
`endif

  // State register plus registered busy/done decodes of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic with clr > ld > en priority.
  always_comb begin
    w_state_nxt = r_state;
    if (clr) begin
      w_state_nxt = ST_IDLE;
    end else if (ld) begin
      w_state_nxt = (din != '0) ? ST_RUN : ST_DONE;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_IDLE;
        ST_RUN: begin
          if (en && w_is_one) begin
            w_state_nxt = ST_DONE;
          end
        end
        ST_DONE: begin
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
          w_state_nxt = (r_reload != '0) ? ST_RUN : ST_IDLE;
`else
          w_state_nxt = ST_IDLE;
`endif
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output decode and counter-core controls.
  always_comb begin
    w_busy_nxt = (w_state_nxt == ST_RUN);
    w_done_nxt = (w_state_nxt == ST_DONE);
    w_core_ld  = ld;
    w_core_din = din;
    w_core_dec = en && (r_state == ST_RUN);
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    if (!ld && (r_state == ST_DONE) && (r_reload != '0)) begin
      w_core_ld  = 1'b1;
      w_core_din = r_reload;
    end
`endif
  end

  dec_core #(
    .n(n)
  ) u_dec_core (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_clr    (clr),
    .i_ld     (w_core_ld),
    .i_dec    (w_core_dec),
    .i_din    (w_core_din),
    .o_q      (w_pout),
    .o_is_one (w_is_one)
  );

  assign pout = w_pout;
  assign busy = r_busy;
  assign done = r_done;
  assign bo   = en & r_busy & w_is_one;

endmodule

// File: tb/tb_down_timer.sv
// Directed self-checking bench for down_timer (width 3).
module tb_down_timer;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       ld;
  logic [2:0] din;
  logic       en;
  logic [2:0] pout;
  logic       busy;
  logic       done;
  logic       bo;

  int errors;
  int checks;

  down_timer #(.n(3)) dut (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .ld   (ld),
    .din  (din),
    .en   (en),
    .pout (pout),
    .busy (busy),
    .done (done),
    .bo   (bo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Return to IDLE between scenarios.
  task automatic do_clr();
    ld  = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; ld = 1'b0; din = 3'd0; en = 1'b1;
    #12;
    checks++; if (pout !== 3'd0) begin errors++; $display("FAIL reset_pout: got %0d want 0", pout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (bo !== 1'b0) begin errors++; $display("FAIL reset_bo: got %b want 0", bo); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_count5();
    ld = 1'b1; din = 3'd5; en = 1'b1;
    tick();
    ld = 1'b0;
    checks++; if (pout !== 3'd5) begin errors++; $display("FAIL cnt5_load_pout: got %0d want 5", pout); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cnt5_load_busy: got %b want 1", busy); end
    for (int k = 4; k >= 0; k--) begin
      checks++;
      if (bo !== ((k + 1) == 1)) begin errors++; $display("FAIL cnt5_bo: pout=%0d got %b want %b", pout, bo, ((k + 1) == 1)); end
      tick();
      checks++; if (pout !== 3'(k)) begin errors++; $display("FAIL cnt5_pout: got %0d want %0d", pout, k); end
      checks++; if (busy !== (k != 0)) begin errors++; $display("FAIL cnt5_busy: k=%0d got %b want %b", k, busy, (k != 0)); end
      checks++; if (done !== (k == 0)) begin errors++; $display("FAIL cnt5_done: k=%0d got %b want %b", k, done, (k == 0)); end
    end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL cnt5_done_pulse: got %b want 0", done); end
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    checks++; if (pout !== 3'd5) begin errors++; $display("FAIL cnt5_reload_pout: got %0d want 5", pout); end
`else
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cnt5_idle_busy: got %b want 0", busy); end
    checks++; if (pout !== 3'd0) begin errors++; $display("FAIL cnt5_idle_pout: got %0d want 0", pout); end
`endif
    do_clr();
  endtask

  task automatic test_en_toggle();
    logic       en_seq   [5];
    logic [2:0] pout_seq [5];
    en_seq   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    pout_seq = '{3'd2, 3'd2, 3'd1, 3'd1, 3'd0};
    ld = 1'b1; din = 3'd3; en = 1'b1;
    tick();
    ld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      en = en_seq[i];
      tick();
      checks++; if (pout !== pout_seq[i]) begin errors++; $display("FAIL tog_pout[%0d]: got %0d want %0d", i, pout, pout_seq[i]); end
      if (i == 3) begin
        en = 1'b0; #1;
        checks++; if (bo !== 1'b0) begin errors++; $display("FAIL tog_bo_en0: got %b want 0", bo); end
        en = 1'b1; #1;
        checks++; if (bo !== 1'b1) begin errors++; $display("FAIL tog_bo_en1: got %b want 1", bo); end
      end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL tog_done: got %b want 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tog_busy: got %b want 0", busy); end
    do_clr();
  endtask

  task automatic test_load_zero();
    ld = 1'b1; din = 3'd0; en = 1'b1;
    tick();
    ld = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL ld0_done: got %b want 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ld0_busy: got %b want 0", busy); end
    checks++; if (pout !== 3'd0) begin errors++; $display("FAIL ld0_pout: got %0d want 0", pout); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL ld0_done_end: got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ld0_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_clr();
    ld = 1'b1; din = 3'd7; en = 1'b1;
    tick();
    ld = 1'b0;
    repeat (3) tick();
    checks++; if (pout !== 3'd4) begin errors++; $display("FAIL clr_pre_pout: got %0d want 4", pout); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (pout !== 3'd0) begin errors++; $display("FAIL clr_pout: got %0d want 0", pout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL clr_done: got %b want 0", done); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL clr_done_after: got %b want 0", done); end
    checks++; if (pout !== 3'd0) begin errors++; $display("FAIL clr_pout_hold: got %0d want 0", pout); end
  endtask

  task automatic test_async_rst();
    ld = 1'b1; din = 3'd7; en = 1'b1;
    tick();
    ld = 1'b0;
    tick();
    checks++; if (pout !== 3'd6) begin errors++; $display("FAIL arst_pre_pout: got %0d want 6", pout); end
    #2 rst = 1'b1;
    #1;
    checks++; if (pout !== 3'd0) begin errors++; $display("FAIL arst_pout: got %0d want 0", pout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL arst_done: got %b want 0", done); end
    checks++; if (bo !== 1'b0) begin errors++; $display("FAIL arst_bo: got %b want 0", bo); end
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL arst_done_after: got %b want 0", done); end
    checks++; if (pout !== 3'd0) begin errors++; $display("FAIL arst_pout_after: got %0d want 0", pout); end
  endtask

  task automatic test_ld_override();
    ld = 1'b1; din = 3'd6; en = 1'b1;
    tick();
    ld = 1'b0;
    repeat (3) tick();
    checks++; if (pout !== 3'd3) begin errors++; $display("FAIL ovr_pre_pout: got %0d want 3", pout); end
    ld = 1'b1; din = 3'd2;
    tick();
    ld = 1'b0;
    checks++; if (pout !== 3'd2) begin errors++; $display("FAIL ovr_pout_load: got %0d want 2", pout); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovr_busy: got %b want 1", busy); end
    tick();
    checks++; if (pout !== 3'd1) begin errors++; $display("FAIL ovr_pout1: got %0d want 1", pout); end
    checks++; if (bo !== 1'b1) begin errors++; $display("FAIL ovr_bo: got %b want 1", bo); end
    tick();
    checks++; if (pout !== 3'd0) begin errors++; $display("FAIL ovr_pout0: got %0d want 0", pout); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL ovr_done: got %b want 1", done); end
    do_clr();
  endtask

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
  task automatic test_auto_reload();
    logic [2:0] pout_seq [6];
    logic       done_seq [6];
    pout_seq = '{3'd1, 3'd0, 3'd2, 3'd1, 3'd0, 3'd2};
    done_seq = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    ld = 1'b1; din = 3'd2; en = 1'b1;
    tick();
    ld = 1'b0;
    checks++; if (pout !== 3'd2) begin errors++; $display("FAIL ar_load_pout: got %0d want 2", pout); end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (pout !== pout_seq[i]) begin errors++; $display("FAIL ar_pout[%0d]: got %0d want %0d", i, pout, pout_seq[i]); end
      checks++; if (done !== done_seq[i]) begin errors++; $display("FAIL ar_done[%0d]: got %b want %b", i, done, done_seq[i]); end
    end
    do_clr();
    tick();
    checks++; if (pout !== 3'd0) begin errors++; $display("FAIL ar_clr_pout: got %0d want 0", pout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_clr_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL ar_clr_done: got %b want 0", done); end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_count5();
    test_en_toggle();
    test_load_zero();
    test_clr();
    test_async_rst();
    test_ld_override();
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    test_auto_reload();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
